// File: rtl/data_mem_pkg.sv
// Shared widths and RISC-V load/store func3 codes for the data memory.
package data_mem_pkg;

  localparam int DataWidth    = 32;
  localparam int AddrWidth    = 32;
  localparam int Func3Width   = 3;
  localparam int DefaultDepth = 1024;

  localparam logic [Func3Width-1:0] LB  = 3'b000;
  localparam logic [Func3Width-1:0] LH  = 3'b001;
  localparam logic [Func3Width-1:0] LW  = 3'b010;
  localparam logic [Func3Width-1:0] LBU = 3'b100;
  localparam logic [Func3Width-1:0] LHU = 3'b101;

  localparam logic [Func3Width-1:0] SB  = 3'b000;
  localparam logic [Func3Width-1:0] SH  = 3'b001;
  localparam logic [Func3Width-1:0] SW  = 3'b010;

endpackage

// File: rtl/data_mem_if.sv
// Load/store port of the data memory. There is no handshake: a load is
// combinational from addr/func3, and a store is taken on every rising clk edge
// where writeEnable is high and reset is low.
interface data_mem_if;
  import data_mem_pkg::*;

  logic [AddrWidth-1:0]  addr;
  logic [DataWidth-1:0]  readData;
  logic                  writeEnable;
  logic [DataWidth-1:0]  writeData;
  logic [AddrWidth-1:0]  PC;
  logic [Func3Width-1:0] func3;

  modport master (
    output addr, writeEnable, writeData, PC, func3,
    input  readData
  );

  modport slave (
    input  addr, writeEnable, writeData, PC, func3,
    output readData
  );

endinterface

// File: rtl/data_mem_load_extend.sv
// Selects the byte/halfword lane of a loaded word and sign/zero-extends it.
module load_extend
  import data_mem_pkg::*;
(
  input  logic [DataWidth-1:0]  i_word,
  input  logic [1:0]            i_lane,
  input  logic [Func3Width-1:0] i_func3,
  output logic [DataWidth-1:0]  o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[7:0];
    case (i_lane)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
  end

  // Halfword lane uses only lane[1]; odd halfword addresses read the aligned half.
  assign w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_result = i_word;
    case (i_func3)
      LB:      o_result = {{24{w_byte[7]}}, w_byte};
      LH:      o_result = {{16{w_half[15]}}, w_half};
      LBU:     o_result = {24'd0, w_byte};
      LHU:     o_result = {16'd0, w_half};
      default: o_result = i_word;
    endcase
  end

endmodule

// File: rtl/data_mem.sv
// Byte-addressed little-endian data memory with combinational loads and
// byte/halfword/word stores merged into the addressed word.
module data_mem
  import data_mem_pkg::*;
#(
  parameter int Depth = DefaultDepth
)(
  input  logic       clk,
  input  logic       reset,
  data_mem_if.slave  bus
);

  localparam int IdxW = $clog2(Depth);

  logic [DataWidth-1:0] r_mem [Depth];

  logic [IdxW-1:0]      w_idx;
  logic [DataWidth-1:0] w_word;
  logic [DataWidth-1:0] w_store_word;
  logic                 w_store_ok;
  logic                 w_unused;

  // Upper address bits alias onto the same words; PC is informational only.
  assign w_idx    = bus.addr[IdxW+1:2];
  assign w_word   = r_mem[w_idx];
  assign w_unused = ^{bus.PC, bus.addr[AddrWidth-1:IdxW+2]};

  load_extend u_load_extend (
    .i_word   (w_word),
    .i_lane   (bus.addr[1:0]),
    .i_func3  (bus.func3),
    .o_result (bus.readData)
  );

  always_comb begin
    w_store_word = w_word;
    w_store_ok   = 1'b0;
    case (bus.func3)
      SB: begin
        w_store_ok = 1'b1;
        case (bus.addr[1:0])
          2'd0:    w_store_word[7:0]   = bus.writeData[7:0];
          2'd1:    w_store_word[15:8]  = bus.writeData[7:0];
          2'd2:    w_store_word[23:16] = bus.writeData[7:0];
          default: w_store_word[31:24] = bus.writeData[7:0];
        endcase
      end
      SH: begin
        w_store_ok = 1'b1;
        if (bus.addr[1]) w_store_word[31:16] = bus.writeData[15:0];
        else             w_store_word[15:0]  = bus.writeData[15:0];
      end
      SW: begin
        w_store_ok   = 1'b1;
        w_store_word = bus.writeData;
      end
      default: w_store_ok = 1'b0;
    endcase
  end

  // Reads see the pre-edge contents; the new word is visible only after the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < Depth; i++) r_mem[i] <= '0;
    end else if (bus.writeEnable && w_store_ok) begin
      r_mem[w_idx] <= w_store_word;
    end
  end

endmodule

// File: tb/tb_data_mem.sv
// Directed bench for data_mem: byte-array reference model, every-cycle read
// compare, and literal expectations for loads, stores, aliasing and reset.
module tb_data_mem;
  import data_mem_pkg::*;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  logic [7:0] m_mem [0:4095];

  data_mem_if bus ();

  data_mem dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f3);
    logic [11:0] b;
    logic [11:0] h;
    logic [11:0] w;
    logic [31:0] word;
    logic [7:0]  bv;
    logic [15:0] hv;
    b    = a[11:0];
    h    = {a[11:1], 1'b0};
    w    = {a[11:2], 2'b00};
    word = {m_mem[w + 12'd3], m_mem[w + 12'd2], m_mem[w + 12'd1], m_mem[w]};
    bv   = m_mem[b];
    hv   = {m_mem[h + 12'd1], m_mem[h]};
    case (f3)
      3'b000:  return (bv >= 8'd128) ? (32'hFFFF_FF00 | {24'd0, bv}) : {24'd0, bv};
      3'b001:  return (hv >= 16'h8000) ? (32'hFFFF_0000 | {16'd0, hv}) : {16'd0, hv};
      3'b100:  return {24'd0, bv};
      3'b101:  return {16'd0, hv};
      default: return word;
    endcase
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d);
    logic [11:0] b;
    b = a[11:0];
    if (f3 == 3'b000) begin
      m_mem[b] = d[7:0];
    end else if (f3 == 3'b001) begin
      b = {b[11:1], 1'b0};
      m_mem[b] = d[7:0];
      m_mem[b + 12'd1] = d[15:8];
    end else if (f3 == 3'b010) begin
      b = {b[11:2], 2'b00};
      for (int k = 0; k < 4; k++) m_mem[b + 12'(k)] = d[8*k +: 8];
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 4096; k++) m_mem[k] = 8'd0;
  endtask

  always @(posedge reset) model_clear();

  always @(posedge clk) begin
    if (!reset && bus.writeEnable) model_store(bus.addr, bus.func3, bus.writeData);
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("cycle_read", bus.readData, model_load(bus.addr, bus.func3));
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d,
                       input logic we);
    bus.addr        = a;
    bus.func3       = f3;
    bus.writeData   = d;
    bus.writeEnable = we;
    bus.PC          = bus.PC + 32'd4;
    tick();
    bus.writeEnable = 1'b0;
  endtask

  task automatic load_check(input string name, input logic [31:0] a, input logic [2:0] f3,
                            input logic [31:0] exp);
    bus.addr        = a;
    bus.func3       = f3;
    bus.writeEnable = 1'b0;
    #1;
    check({name, "_dut"}, bus.readData, exp);
    check({name, "_model"}, model_load(a, f3), exp);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    n_cmp = 0;
    n_bad = 0;
    model_clear();
    reset           = 1'b1;
    bus.addr        = '0;
    bus.func3       = LW;
    bus.writeData   = '0;
    bus.writeEnable = 1'b0;
    bus.PC          = 32'h0000_1000;
    repeat (3) tick();

    // store request while reset is still high at the edge: ignored
    store(32'h040, SW, 32'hFFFF_FFFF, 1'b1);
    reset = 1'b0;
    tick();
    load_check("rst_lw_000", 32'h000, LW, 32'h0000_0000);
    load_check("rst_lw_7fc", 32'h7FC, LW, 32'h0000_0000);
    load_check("rst_ignored_store", 32'h040, LW, 32'h0000_0000);
    tick();

    store(32'h010, SW, 32'h8081_F2A3, 1'b1);
    load_check("lw_010",  32'h010, LW,  32'h8081_F2A3);
    load_check("lb_010",  32'h010, LB,  32'hFFFF_FFA3);
    load_check("lbu_013", 32'h013, LBU, 32'h0000_0080);
    load_check("lh_012",  32'h012, LH,  32'hFFFF_8081);
    load_check("lhu_010", 32'h010, LHU, 32'h0000_F2A3);
    load_check("lb_011",  32'h011, LB,  32'hFFFF_FFF2);
    load_check("lw_013_aligned", 32'h013, LW, 32'h8081_F2A3);
    tick();

    store(32'h011, SB, 32'hFFFF_FF55, 1'b1);
    store(32'h012, SH, 32'hABCD_1234, 1'b1);
    load_check("merge_lw_010", 32'h010, LW,  32'h1234_55A3);
    load_check("lhu_011_odd",  32'h011, LHU, 32'h0000_55A3);
    load_check("lh_013_odd",   32'h013, LH,  32'h0000_1234);
    load_check("rsv011_load",  32'h012, 3'b011, 32'h1234_55A3);
    load_check("rsv111_load",  32'h011, 3'b111, 32'h1234_55A3);
    tick();

    store(32'h020, SW, 32'hCAFE_BABE, 1'b0);
    load_check("we0_lw_020", 32'h020, LW, 32'h0000_0000);
    tick();
    store(32'h1004, SW, 32'hDEAD_BEEF, 1'b1);
    load_check("alias_lw_004",  32'h004, LW, 32'hDEAD_BEEF);
    load_check("alias_lw_ff004", 32'hFFFF_F004, LW, 32'hDEAD_BEEF);
    tick();

    store(32'h030, 3'b011, 32'hFFFF_FFFF, 1'b1);
    store(32'h030, 3'b110, 32'hFFFF_FFFF, 1'b1);
    store(32'h030, LBU,    32'hFFFF_FFFF, 1'b1);
    load_check("rsv_store_030", 32'h030, LW, 32'h0000_0000);
    tick();

    // high byte store into the last word of memory
    store(32'hFFF, SB, 32'h0000_0080, 1'b1);
    load_check("sb_fff_lw",  32'hFFC, LW, 32'h8000_0000);
    load_check("sb_fff_lb",  32'hFFF, LB, 32'hFFFF_FF80);
    tick();

    // asynchronous reset mid-cycle: reads drop to zero before the next edge
    reset = 1'b1;
    load_check("async_rst_010", 32'h010, LW, 32'h0000_0000);
    load_check("async_rst_004", 32'h004, LW, 32'h0000_0000);
    load_check("async_rst_ffc", 32'hFFC, LW, 32'h0000_0000);
    store(32'h050, SW, 32'h1111_2222, 1'b1);
    reset = 1'b0;
    tick();
    load_check("post_rst_050", 32'h050, LW, 32'h0000_0000);
    tick();

    store(32'h050, SW, 32'h1111_2222, 1'b1);
    load_check("post_rst_store", 32'h050, LW, 32'h1111_2222);
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_mem.md
DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 clk  input  1  sole clock; all memory updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 addr  input  32 (AddrWidth)  byte address of the access.
REQ-004 readData  output  32 (DataWidth)  load result, already sign/zero-extended per func3.
REQ-005 writeEnable  input  1  store strobe, sampled at rising clk.
REQ-006 writeData  input  32  store source; low byte/halfword/word used per func3.
REQ-007 PC  input  32  program counter of the current instruction; informational only, no functional effect.
REQ-008 func3  input  3 (Func3Width)  RISC-V load/store width code.

Function
REQ-009 Storage SHALL be 1024 x 32-bit words (4 KiB), byte-addressed, little-endian; word index = addr[11:2], addr[31:12] ignored (wrap-around aliasing).
REQ-010 Read SHALL be combinational from addr/func3/memory contents; zero latency.
REQ-011 Load decode: 000 LB sign-extend byte; 001 LH sign-extend halfword; 010 LW full word; 100 LBU zero-extend byte; 101 LHU zero-extend halfword.
REQ-012 Byte lane = addr[1:0]; halfword lane = addr[1] (addr[0] ignored); word access ignores addr[1:0]. No misalignment trap.
REQ-013 Reserved func3 (011, 110, 111) SHALL read the full aligned word.
REQ-014 Store on rising clk when writeEnable=1 and reset=0: 000 SB writes writeData[7:0] to selected byte lane; 001 SH writes writeData[15:0] to selected halfword lane; 010 SW writes full word.
REQ-015 Stores SHALL leave unselected byte lanes of the word unchanged.
REQ-016 Store with any other func3 SHALL not modify memory.
REQ-017 Read of the address being written in the same cycle SHALL return old data before the edge and new data after it (no bypass).
REQ-018 writeEnable=0 SHALL never modify memory, regardless of addr/writeData/func3 changes.

Reset
REQ-019 While reset=1, all 1024 words SHALL be cleared to 0 asynchronously, and stores SHALL be ignored.
REQ-020 readData SHALL therefore be 0 for every address during reset and after it until a store occurs.
REQ-021 A store coinciding with reset deassertion in the same cycle SHALL be ignored; the first accepted store is at the first rising edge with reset already low.

Structure
REQ-022 DataWidth, AddrWidth, Func3Width and the func3 codes (LB/LH/LW/LBU/LHU, SB/SH/SW) SHALL live in the shared Defines package; memory depth SHALL be a module parameter (default 1024).
REQ-023 Load lane selection and extension SHALL be a combinational sub-module load_extend (inputs word, addr[1:0], func3; output 32-bit result); store merge stays in data_mem.

Verification
REQ-024 Reset pulse, then LW at 0x000, 0x7FC -> readData 0x00000000.
REQ-025 SW 0x8081F2A3 at 0x010; LW 0x010 -> 0x8081F2A3; LB 0x010 -> 0xFFFFFFA3; LBU 0x013 -> 0x00000080; LH 0x012 -> 0xFFFF8081; LHU 0x010 -> 0x0000F2A3.
REQ-026 After REQ-025, SB 0x55 at 0x011 then SH 0x1234 at 0x012; LW 0x010 -> 0x123455A3.
REQ-027 SW with writeEnable=0 at 0x020 -> LW 0x020 stays 0; SW 0xDEADBEEF at 0x1004 -> LW 0x004 returns 0xDEADBEEF (aliasing).
REQ-028 Store func3=011 at 0x030 -> memory unchanged; assert reset mid-run after stores -> all reads 0 immediately, before next clk edge.
